de_data_reader: RTL and testbench

- Read-back engine for the DE RAM (decrypted data, 32 words x 8 bits). It is the counterpart of the DE writer, which fills that RAM once a key is found.
- On a start pulse it sequences addresses 0..31 into the DE RAM read port and absorbs the RAM's one-cycle read latency.
- Each byte is presented on a valid/ready byte stream, for a UART/LCD sink or for bench checking.
- It owns no RAM; the top level muxes the DE RAM address port to this block while busy is high.

---
 rtl/de_data_reader.sv | 156 +++++++++++++++
 tb/tb_de_data_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de_data_reader.sv
// Read-back engine for the DE RAM: streams words 0..DEPTH-1 out over a valid/ready byte interface.
// Optional XOR checksum output is enabled by defining DE_READ_CHECKSUM_EN.
module de_data_reader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef DE_READ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W-1:0]   idx_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_W-1:0]   data_nxt_s;
    logic [ADDR_W-1:0]   index_nxt_s;
    logic                valid_nxt_s;
    logic                done_nxt_s;
    logic                busy_nxt_s;
    logic                xfer_s;
    logic                start_acc_s;

    assign xfer_s      = (state_r == ST_PRESENT) && out_valid && out_ready;
    assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Next-state and next-output computation for the read sequencer.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        addr_nxt_s  = ram_address;
        data_nxt_s  = out_data;
        index_nxt_s = out_index;
        valid_nxt_s = out_valid;
        done_nxt_s  = done;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    done_nxt_s  = 1'b0;
                    addr_nxt_s  = '0;
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT: begin
                state_nxt_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_nxt_s  = ram_q;
                index_nxt_s = idx_r;
                valid_nxt_s = 1'b1;
                state_nxt_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                // start is deliberately not looked at here, even on the final transfer
                if (xfer_s && (idx_r == LAST_IDX)) begin
                    valid_nxt_s = 1'b0;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (xfer_s) begin
                    valid_nxt_s = 1'b0;
                    idx_nxt_s   = idx_r + 1'b1;
                    addr_nxt_s  = idx_r + 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                done_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_CAPTURE) ||
                     (state_nxt_s == ST_PRESENT);
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            ram_address <= '0;
            out_data    <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            ram_address <= addr_nxt_s;
            out_data    <= data_nxt_s;
            out_index   <= index_nxt_s;
            out_valid   <= valid_nxt_s;
            busy        <= busy_nxt_s;
            done        <= done_nxt_s;
        end
    end

`ifdef DE_READ_CHECKSUM_EN
    logic [DATA_W-1:0] chk_nxt_s;

    // Checksum update: cleared by an accepted start, XOR of every transferred byte.
    always_comb begin
        chk_nxt_s = checksum;
        if (start_acc_s) begin
            chk_nxt_s = '0;
        end else if (xfer_s) begin
            chk_nxt_s = checksum ^ out_data;
        end else begin
            chk_nxt_s = checksum;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else begin
            checksum <= chk_nxt_s;
        end
    end
`else
    logic unused_s;
    assign unused_s = start_acc_s;
`endif

endmodule

// File: tb/tb_de_data_reader.sv
// Scoreboard bench for de_data_reader: directed runs with a synchronous RAM model,
// backpressure, spurious starts, mid-run reset and restart from DONE.
module tb_de_data_reader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       out_ready;
    logic [7:0] ram_q;
    logic [4:0] ram_address;
    logic [7:0] out_data;
    logic [4:0] out_index;
    logic       out_valid;
    logic       busy;
    logic       done;
`ifdef DE_READ_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0]  mem [0:31];
    logic [12:0] exp_q [$];
    int cyc     = 0;
    int n_checks = 0;
    int n_fail  = 0;
    int n_xfer  = 0;

    always #5 clk = ~clk;

    de_data_reader #(.DEPTH(32), .ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ram_address(ram_address),
        .ram_q(ram_q),
        .out_data(out_data),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
`ifdef DE_READ_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always @(posedge clk) ram_q <= mem[ram_address];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every transfer pops the scoreboard and compares.
    always @(negedge clk) begin : monitor
        logic [12:0] e;
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: got index %0d data 0x%0h, expected no transfer", out_index, out_data);
            end else begin
                e = exp_q.pop_front();
                check("xfer_index", {27'd0, out_index}, {27'd0, e[12:8]});
                check("xfer_data", {24'd0, out_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), mem[i]});
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input int c0, input int exp_done, input string tag);
        int first = -1;
        int dn    = -1;
        for (int k = 0; k < 400; k++) begin
            if (out_valid && first < 0) first = cyc - c0;
            if (done) begin
                dn = cyc - c0;
                break;
            end
            tick();
        end
        check({tag, "_first_valid_cycle"}, 32'(first), 32'd3);
        check({tag, "_done_cycle"}, 32'(dn), 32'(exp_done));
        check({tag, "_busy_after_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_count(input int x0, input string tag);
        check({tag, "_xfer_count"}, 32'(n_xfer - x0), 32'd32);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0;
        int x0;
        bit found;
        for (int i = 0; i < 32; i++) mem[i] = 8'h61 + 8'(i % 26);
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_address", {27'd0, ram_address}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        reset = 1'b1;
        tick();

        // Straight run with out_ready high
        x0 = n_xfer;
        push_all();
        pulse_start(c0);
        wait_run(c0, 97, "run1");
        check_count(x0, "run1");

        // Five-cycle stall on byte 7
        x0 = n_xfer;
        push_all();
        found = 1'b0;
        fork
            begin
                pulse_start(c0);
                wait_run(c0, 102, "stall");
            end
            begin
                for (int k = 0; k < 150 && !found; k++) begin
                    if (out_valid && out_index == 5'd7) begin
                        found = 1'b1;
                        out_ready = 1'b0;
                        for (int j = 0; j < 5; j++) begin
                            check("stall_valid", {31'd0, out_valid}, 32'd1);
                            check("stall_data", {24'd0, out_data}, 32'h68);
                            check("stall_index", {27'd0, out_index}, 32'd7);
                            tick();
                        end
                        out_ready = 1'b1;
                    end else begin
                        tick();
                    end
                end
            end
        join
        check("stall_seen", {31'd0, found}, 32'd1);
        check_count(x0, "stall");

        // Spurious starts in cycles 10 and 96
        x0 = n_xfer;
        push_all();
        pulse_start(c0);
        fork
            wait_run(c0, 97, "xstart");
            begin
                while (cyc < c0 + 10) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
                while (cyc < c0 + 96) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        repeat (5) tick();
        check("xstart_done_held", {31'd0, done}, 32'd1);
        check("xstart_busy_idle", {31'd0, busy}, 32'd0);
        check_count(x0, "xstart");

        // Restart from DONE with inverted contents
        for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'hFF;
        x0 = n_xfer;
        push_all();
        pulse_start(c0);
        check("restart_done_drop", {31'd0, done}, 32'd0);
        wait_run(c0, 97, "restart");
        check_count(x0, "restart");

        // Reset mid-run while byte 12 is presented
        for (int i = 0; i < 32; i++) mem[i] = 8'h61 + 8'(i % 26);
        push_all();
        pulse_start(c0);
        found = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (out_valid && out_index == 5'd12) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reset_point_seen", {31'd0, found}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_address", {27'd0, ram_address}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_index", {27'd0, out_index}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        repeat (4) tick();
        check("idle_after_rst_busy", {31'd0, busy}, 32'd0);
        check("idle_after_rst_valid", {31'd0, out_valid}, 32'd0);
        x0 = n_xfer;
        push_all();
        pulse_start(c0);
        wait_run(c0, 97, "postrst");
        check_count(x0, "postrst");

`ifdef DE_READ_CHECKSUM_EN
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        x0 = n_xfer;
        push_all();
        pulse_start(c0);
        wait_run(c0, 97, "chk0");
        check("checksum_identity", {24'd0, checksum}, 32'h00);
        mem[5] = 8'h80;
        push_all();
        pulse_start(c0);
        wait_run(c0, 97, "chk1");
        check("checksum_word5", {24'd0, checksum}, 32'h85);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
